// File: rtl/fourbyfour_y_reader.sv
// Readout for the 4x4 CNN array: snapshots Y1..Y16 on every ITERS-th frame strobe and
// streams the 16 cell states in raster order over a valid/ready interface.
module fourbyfour_y_reader #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned ITERS = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic signed [2*WIDTH-1:0] Y1_in,
  input  logic signed [2*WIDTH-1:0] Y2_in,
  input  logic signed [2*WIDTH-1:0] Y3_in,
  input  logic signed [2*WIDTH-1:0] Y4_in,
  input  logic signed [2*WIDTH-1:0] Y5_in,
  input  logic signed [2*WIDTH-1:0] Y6_in,
  input  logic signed [2*WIDTH-1:0] Y7_in,
  input  logic signed [2*WIDTH-1:0] Y8_in,
  input  logic signed [2*WIDTH-1:0] Y9_in,
  input  logic signed [2*WIDTH-1:0] Y10_in,
  input  logic signed [2*WIDTH-1:0] Y11_in,
  input  logic signed [2*WIDTH-1:0] Y12_in,
  input  logic signed [2*WIDTH-1:0] Y13_in,
  input  logic signed [2*WIDTH-1:0] Y14_in,
  input  logic signed [2*WIDTH-1:0] Y15_in,
  input  logic signed [2*WIDTH-1:0] Y16_in,
  input  logic                      frame_strobe,
  input  logic                      clr_overrun,
  output logic signed [2*WIDTH-1:0] out_data,
  output logic                      out_sign,
  output logic [3:0]                out_idx,
  output logic                      out_valid,
  output logic                      out_last,
  input  logic                      out_ready,
  output logic                      busy,
  output logic                      overrun,
  output logic [7:0]                frame_count
);

  localparam int unsigned DW = 2 * WIDTH;

  typedef enum logic [0:0] {StIdle, StStream} state_e;

  state_e        state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [7:0]    it_cnt_q, it_cnt_d;
  logic [7:0]    frame_count_q, frame_count_d;
  logic          overrun_q, overrun_d;
  logic [DW-1:0] s_q [16];
  logic [DW-1:0] y [16];
  logic          due, handshake, last_hs, capture;

  assign y[0]  = Y1_in;
  assign y[1]  = Y2_in;
  assign y[2]  = Y3_in;
  assign y[3]  = Y4_in;
  assign y[4]  = Y5_in;
  assign y[5]  = Y6_in;
  assign y[6]  = Y7_in;
  assign y[7]  = Y8_in;
  assign y[8]  = Y9_in;
  assign y[9]  = Y10_in;
  assign y[10] = Y11_in;
  assign y[11] = Y12_in;
  assign y[12] = Y13_in;
  assign y[13] = Y14_in;
  assign y[14] = Y15_in;
  assign y[15] = Y16_in;

  // Compare in 9 bits so it_cnt+1 cannot wrap onto ITERS.
  assign due = frame_strobe && (({1'b0, it_cnt_q} + 9'd1) == 9'(ITERS));

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    it_cnt_d      = it_cnt_q;
    frame_count_d = frame_count_q;
    overrun_d     = overrun_q;

    handshake = (state_q == StStream) && out_ready;
    last_hs   = handshake && (idx_q == 4'd15);
    // A due strobe coinciding with the final handshake chains straight into the next frame.
    capture   = due && ((state_q == StIdle) || last_hs);

    if (frame_strobe) begin
      it_cnt_d = due ? 8'd0 : it_cnt_q + 8'd1;
    end

    if (handshake) begin
      if (last_hs) begin
        frame_count_d = frame_count_q + 8'd1;
        state_d       = StIdle;
        idx_d         = 4'd0;
      end else begin
        idx_d = idx_q + 4'd1;
      end
    end

    if (capture) begin
      state_d = StStream;
      idx_d   = 4'd0;
    end

    if (due && !capture) begin
      overrun_d = 1'b1;
    end else if (clr_overrun) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      idx_q         <= 4'd0;
      it_cnt_q      <= 8'd0;
      frame_count_q <= 8'd0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      it_cnt_q      <= it_cnt_d;
      frame_count_q <= frame_count_d;
      overrun_q     <= overrun_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        s_q[i] <= '0;
      end
    end else if (capture) begin
      for (int i = 0; i < 16; i++) begin
        s_q[i] <= y[i];
      end
    end
  end

  assign out_valid   = (state_q == StStream);
  assign busy        = out_valid;
  assign out_idx     = idx_q;
  assign out_last    = out_valid && (idx_q == 4'd15);
  assign out_data    = out_valid ? s_q[idx_q] : '0;
  assign out_sign    = out_valid & ~out_data[DW-1];
  assign overrun     = overrun_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_fourbyfour_y_reader.sv
// Bench for fourbyfour_y_reader: two instances (ITERS=1 and ITERS=3) share stimulus and are
// checked every cycle against a frame-level reference model.
module tb_fourbyfour_y_reader;

  localparam int unsigned WIDTH = 9;
  localparam int unsigned DW    = 2 * WIDTH;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] y_in [16];
  logic          frame_strobe, clr_overrun, out_ready;

  logic [DW-1:0] d1_data, d3_data;
  logic          d1_sign, d3_sign, d1_valid, d3_valid, d1_last, d3_last;
  logic          d1_busy, d3_busy, d1_ovr, d3_ovr;
  logic [3:0]    d1_idx, d3_idx;
  logic [7:0]    d1_fc, d3_fc;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state, one slot per instance.
  logic [DW-1:0] m_frame [2][16];
  bit            m_pend [2];
  int            m_pos [2];
  int            m_cnt [2];
  bit            m_ovr [2];
  int            m_fc [2];

  always #5 clk = ~clk;

  fourbyfour_y_reader #(.WIDTH(WIDTH), .ITERS(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .Y1_in(y_in[0]), .Y2_in(y_in[1]), .Y3_in(y_in[2]), .Y4_in(y_in[3]),
    .Y5_in(y_in[4]), .Y6_in(y_in[5]), .Y7_in(y_in[6]), .Y8_in(y_in[7]),
    .Y9_in(y_in[8]), .Y10_in(y_in[9]), .Y11_in(y_in[10]), .Y12_in(y_in[11]),
    .Y13_in(y_in[12]), .Y14_in(y_in[13]), .Y15_in(y_in[14]), .Y16_in(y_in[15]),
    .frame_strobe(frame_strobe), .clr_overrun(clr_overrun),
    .out_data(d1_data), .out_sign(d1_sign), .out_idx(d1_idx), .out_valid(d1_valid),
    .out_last(d1_last), .out_ready(out_ready), .busy(d1_busy), .overrun(d1_ovr),
    .frame_count(d1_fc)
  );

  fourbyfour_y_reader #(.WIDTH(WIDTH), .ITERS(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .Y1_in(y_in[0]), .Y2_in(y_in[1]), .Y3_in(y_in[2]), .Y4_in(y_in[3]),
    .Y5_in(y_in[4]), .Y6_in(y_in[5]), .Y7_in(y_in[6]), .Y8_in(y_in[7]),
    .Y9_in(y_in[8]), .Y10_in(y_in[9]), .Y11_in(y_in[10]), .Y12_in(y_in[11]),
    .Y13_in(y_in[12]), .Y14_in(y_in[13]), .Y15_in(y_in[14]), .Y16_in(y_in[15]),
    .frame_strobe(frame_strobe), .clr_overrun(clr_overrun),
    .out_data(d3_data), .out_sign(d3_sign), .out_idx(d3_idx), .out_valid(d3_valid),
    .out_last(d3_last), .out_ready(out_ready), .busy(d3_busy), .overrun(d3_ovr),
    .frame_count(d3_fc)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare outputs with the model, then apply this cycle's inputs to the model.
  task automatic model_cycle(input int d, input int iters, input logic v, input logic [3:0] ix,
                             input logic [DW-1:0] dt, input logic sg, input logic ls,
                             input logic bz, input logic ov, input logic [7:0] fc);
    string p;
    bit    due, set_ovr;
    p = $sformatf("i%0d_", iters);
    if (!rst_n) begin
      m_pend[d] = 0; m_pos[d] = 0; m_cnt[d] = 0; m_ovr[d] = 0; m_fc[d] = 0;
      check_eq({p, "rst_idx"}, 32'(ix), 32'd0);
    end
    check_eq({p, "valid"}, 32'(v), 32'(m_pend[d]));
    check_eq({p, "busy"}, 32'(bz), 32'(m_pend[d]));
    check_eq({p, "last"}, 32'(ls), 32'(m_pend[d] && m_pos[d] == 15));
    check_eq({p, "overrun"}, 32'(ov), 32'(m_ovr[d]));
    check_eq({p, "frames"}, 32'(fc), 32'(m_fc[d]));
    if (m_pend[d]) begin
      check_eq({p, "idx"}, 32'(ix), 32'(m_pos[d]));
      check_eq({p, "data"}, 32'(dt), 32'(m_frame[d][m_pos[d]]));
      check_eq({p, "sign"}, 32'(sg), 32'($signed(m_frame[d][m_pos[d]]) >= 0));
    end else begin
      check_eq({p, "idle_data"}, 32'(dt), 32'd0);
      check_eq({p, "idle_sign"}, 32'(sg), 32'd0);
    end
    if (!rst_n) return;

    if (m_pend[d] && out_ready) begin
      if (m_pos[d] == 15) begin
        m_pend[d] = 0;
        m_fc[d]   = (m_fc[d] + 1) % 256;
      end else begin
        m_pos[d]++;
      end
    end
    set_ovr = 0;
    if (frame_strobe) begin
      due      = (m_cnt[d] + 1 == iters);
      m_cnt[d] = due ? 0 : m_cnt[d] + 1;
      if (due) begin
        if (!m_pend[d]) begin
          for (int i = 0; i < 16; i++) m_frame[d][i] = y_in[i];
          m_pend[d] = 1;
          m_pos[d]  = 0;
        end else begin
          set_ovr = 1;
        end
      end
    end
    if (set_ovr) m_ovr[d] = 1;
    else if (clr_overrun) m_ovr[d] = 0;
  endtask

  always @(negedge clk) begin
    model_cycle(0, 1, d1_valid, d1_idx, d1_data, d1_sign, d1_last, d1_busy, d1_ovr, d1_fc);
    model_cycle(1, 3, d3_valid, d3_idx, d3_data, d3_sign, d3_last, d3_busy, d3_ovr, d3_fc);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe_once();
    frame_strobe = 1'b1;
    step();
    frame_strobe = 1'b0;
  endtask

  task automatic rand_y();
    for (int i = 0; i < 16; i++) y_in[i] = DW'($urandom());
  endtask

  initial begin
    bit found;
    rst_n        = 1'b0;
    frame_strobe = 1'b0;
    clr_overrun  = 1'b0;
    out_ready    = 1'b0;
    for (int i = 0; i < 16; i++) y_in[i] = '0;
    step();
    step();
    rst_n = 1'b1;
    step();

    // Ramp frame, ready held high.
    for (int k = 1; k <= 16; k++) y_in[k-1] = DW'(k * 1000 - 8000);
    out_ready = 1'b1;
    strobe_once();
    repeat (20) step();
    check_eq("ramp_frames", 32'(d1_fc), 32'd1);

    // Backpressure 1,0,0 with inputs scrambled after capture.
    rand_y();
    strobe_once();
    for (int i = 0; i < 60; i++) begin
      out_ready = (i % 3 == 0);
      rand_y();
      step();
    end
    out_ready = 1'b1;
    repeat (20) step();

    // Overrun while stalled, then clear.
    out_ready = 1'b0;
    rand_y();
    strobe_once();
    repeat (5) step();
    rand_y();
    strobe_once();
    step();
    check_eq("ovr_set", 32'(d1_ovr), 32'd1);
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
    check_eq("ovr_clr", 32'(d1_ovr), 32'd0);
    out_ready = 1'b1;
    repeat (20) step();

    // Seamless: second strobe lands on the idx-15 handshake.
    rand_y();
    strobe_once();
    repeat (15) step();
    rand_y();
    strobe_once();
    check_eq("seam_idx", 32'(d1_idx), 32'd0);
    check_eq("seam_ovr", 32'(d1_ovr), 32'd0);
    repeat (20) step();

    // Reset at idx 7.
    rand_y();
    strobe_once();
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (d1_valid && d1_idx == 4'd7) found = 1;
      else step();
    end
    check_eq("wait_idx7", 32'(found), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("abort_valid", 32'(d1_valid), 32'd0);
    check_eq("abort_frames", 32'(d1_fc), 32'd0);
    step();
    rst_n = 1'b1;
    repeat (5) step();
    check_eq("post_rst_idle", 32'(d1_valid), 32'd0);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      rand_y();
      frame_strobe = ($urandom_range(0, 9) == 0);
      out_ready    = ($urandom_range(0, 3) != 0);
      clr_overrun  = ($urandom_range(0, 19) == 0);
      step();
    end
    frame_strobe = 1'b0;
    clr_overrun  = 1'b0;
    out_ready    = 1'b1;
    repeat (20) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
